// File: rtl/cnt_pkg.sv
// Shared definitions for the up/down counter and its command front end.
package cnt_pkg;
    localparam int CW = 4;
endpackage

// File: rtl/cnt_cmd_ctrl_if.sv
// Board-side button/switch inputs and the conditioned counter commands.
interface cnt_cmd_ctrl_if;
    import cnt_pkg::*;

    logic          btn_load;
    logic          btn_dir;
    logic [CW-1:0] sw_val;
    logic          load;
    logic          down;
    logic [CW-1:0] cnt_in;

    modport master (
        output btn_load, btn_dir, sw_val,
        input  load, down, cnt_in
    );

    modport slave (
        input  btn_load, btn_dir, sw_val,
        output load, down, cnt_in
    );
endinterface

// File: rtl/db_sync.sv
// Two-flop synchroniser followed by a counter-based debouncer for one raw button.
module db_sync #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);
    localparam int                CNT_W   = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             db_q;
    logic [CNT_W-1:0] cnt_q;

    // The state only flips after DB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            db_q   <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], din};
            if (sync_q[1] != db_q) begin
                if (cnt_q == CNT_MAX) begin
                    db_q  <= ~db_q;
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign dout = db_q;
endmodule

// File: rtl/cnt_cmd_ctrl.sv
// Turns raw load/direction buttons and a switch bank into a clean load pulse,
// a registered load value and a toggling direction level for the counter.
module cnt_cmd_ctrl
    import cnt_pkg::*;
#(
    parameter int DB_CYCLES = 4
) (
    input logic           clk,
    input logic           rst,
    cnt_cmd_ctrl_if.slave cmd
);
    logic          ld_db, dir_db;
    logic          ld_rise, dir_rise;
    logic [CW-1:0] sw_s1_q, sw_s2_q;
    logic          ld_db_q, dir_db_q;
    logic          load_q, load_d;
    logic          down_q, down_d;
    logic [CW-1:0] cnt_in_q, cnt_in_d;

    db_sync #(.DB_CYCLES(DB_CYCLES)) u_db_load (
        .clk  (clk),
        .rst  (rst),
        .din  (cmd.btn_load),
        .dout (ld_db)
    );

    db_sync #(.DB_CYCLES(DB_CYCLES)) u_db_dir (
        .clk  (clk),
        .rst  (rst),
        .din  (cmd.btn_dir),
        .dout (dir_db)
    );

    // Both paths are independent, so simultaneous presses act in the same cycle.
    always_comb begin
        ld_rise  = ld_db & ~ld_db_q;
        dir_rise = dir_db & ~dir_db_q;
        load_d   = ld_rise;
        cnt_in_d = ld_rise ? sw_s2_q : cnt_in_q;
        down_d   = dir_rise ? ~down_q : down_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
            ld_db_q  <= 1'b0;
            dir_db_q <= 1'b0;
            load_q   <= 1'b0;
            down_q   <= 1'b0;
            cnt_in_q <= '0;
        end else begin
            sw_s1_q  <= cmd.sw_val;
            sw_s2_q  <= sw_s1_q;
            ld_db_q  <= ld_db;
            dir_db_q <= dir_db;
            load_q   <= load_d;
            down_q   <= down_d;
            cnt_in_q <= cnt_in_d;
        end
    end

    assign cmd.load   = load_q;
    assign cmd.down   = down_q;
    assign cmd.cnt_in = cnt_in_q;
endmodule

// File: tb/tb_cnt_cmd_ctrl.sv
// Bench for cnt_cmd_ctrl: directed scenarios plus randomized buttons against a window-based model.
module tb_cnt_cmd_ctrl;
    import cnt_pkg::*;

    localparam int DB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    cnt_cmd_ctrl_if cmd();

    cnt_cmd_ctrl #(.DB_CYCLES(DB)) dut (
        .clk (clk),
        .rst (rst),
        .cmd (cmd)
    );

    always #5 clk = ~clk;

    // Reference model: a button's debounced state flips once the DB most recent
    // synchronised samples (raw samples two edges old) all disagree with it.
    logic [DB:0]   h_ld, h_dir;
    logic [CW-1:0] h_sw [2];
    logic          st_ld, st_dir, prev_ld, prev_dir;
    logic          m_load, m_down;
    logic [CW-1:0] m_cnt;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_ld     <= '0;
            h_dir    <= '0;
            h_sw[0]  <= '0;
            h_sw[1]  <= '0;
            st_ld    <= 1'b0;
            st_dir   <= 1'b0;
            prev_ld  <= 1'b0;
            prev_dir <= 1'b0;
            m_load   <= 1'b0;
            m_down   <= 1'b0;
            m_cnt    <= '0;
        end else begin
            m_load <= st_ld & ~prev_ld;
            if (st_ld & ~prev_ld) m_cnt <= h_sw[1];
            if (st_dir & ~prev_dir) m_down <= ~m_down;
            prev_ld  <= st_ld;
            prev_dir <= st_dir;
            if (h_ld[DB:1] == {DB{~st_ld}}) st_ld <= ~st_ld;
            if (h_dir[DB:1] == {DB{~st_dir}}) st_dir <= ~st_dir;
            h_ld    <= {h_ld[DB-1:0], cmd.btn_load};
            h_dir   <= {h_dir[DB-1:0], cmd.btn_dir};
            h_sw[0] <= cmd.sw_val;
            h_sw[1] <= h_sw[0];
        end
    end

    task automatic test_reset();
        cmd.btn_load = 1'b0;
        cmd.btn_dir  = 1'b0;
        cmd.sw_val   = 4'hF;
        #1 rst = 1'b0;
        #1;
        n_tests++;
        if (cmd.load !== 1'b0 || cmd.down !== 1'b0 || cmd.cnt_in !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_immediate load=%b down=%b cnt_in=%h required 0/0/0", cmd.load, cmd.down, cmd.cnt_in);
        end
        for (int i = 0; i < 10; i++) begin
            cmd.btn_load = 1'($urandom_range(0, 1));
            cmd.btn_dir  = 1'($urandom_range(0, 1));
            cmd.sw_val   = CW'($urandom_range(0, 15));
            @(negedge clk);
            n_tests++;
            if (cmd.load !== 1'b0 || cmd.down !== 1'b0 || cmd.cnt_in !== 4'h0) begin
                n_fail++;
                $display("FAIL reset_hold cyc%0d load=%b down=%b cnt_in=%h required 0/0/0", i, cmd.load, cmd.down, cmd.cnt_in);
            end
        end
        cmd.btn_load = 1'b0;
        cmd.btn_dir  = 1'b0;
        rst = 1'b1;
    endtask

    task automatic test_clean_load();
        cmd.sw_val   = 4'b1010;
        cmd.btn_load = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            if (i == 21) cmd.btn_load = 1'b0;
            @(negedge clk);
            n_tests++;
            if (cmd.load !== (i == 7)) begin
                n_fail++;
                $display("FAIL clean_load_pulse cyc%0d load=%b required %b", i, cmd.load, (i == 7));
            end
            n_tests++;
            if (cmd.cnt_in !== ((i >= 7) ? 4'hA : 4'h0)) begin
                n_fail++;
                $display("FAIL clean_load_value cyc%0d cnt_in=%h required %h", i, cmd.cnt_in, (i >= 7) ? 4'hA : 4'h0);
            end
        end
    endtask

    task automatic test_glitch();
        cmd.btn_load = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            if (i == 4) cmd.btn_load = 1'b0;
            @(negedge clk);
            n_tests++;
            if (cmd.load !== 1'b0) begin
                n_fail++;
                $display("FAIL glitch cyc%0d load=%b required 0", i, cmd.load);
            end
        end
    endtask

    task automatic test_dir_toggle();
        logic old_down;
        logic new_down;
        old_down = 1'b0;
        for (int k = 0; k < 3; k++) begin
            new_down = ~old_down;
            cmd.btn_dir = 1'b1;
            for (int i = 1; i <= 20; i++) begin
                if (i == 11) cmd.btn_dir = 1'b0;
                @(negedge clk);
                n_tests++;
                if (cmd.down !== ((i >= 7) ? new_down : old_down)) begin
                    n_fail++;
                    $display("FAIL dir_toggle press%0d cyc%0d down=%b required %b", k, i, cmd.down, (i >= 7) ? new_down : old_down);
                end
            end
            old_down = new_down;
        end
    endtask

    task automatic test_simultaneous();
        cmd.sw_val   = 4'h5;
        cmd.btn_load = 1'b1;
        cmd.btn_dir  = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            if (i == 11) begin
                cmd.btn_load = 1'b0;
                cmd.btn_dir  = 1'b0;
            end
            @(negedge clk);
            n_tests++;
            if (cmd.load !== (i == 7) || cmd.down !== (i < 7) || cmd.cnt_in !== ((i >= 7) ? 4'h5 : 4'hA)) begin
                n_fail++;
                $display("FAIL simultaneous cyc%0d load=%b down=%b cnt_in=%h required %b/%b/%h",
                         i, cmd.load, cmd.down, cmd.cnt_in, (i == 7), (i < 7), (i >= 7) ? 4'h5 : 4'hA);
            end
        end
    endtask

    task automatic test_reset_mid();
        cmd.btn_load = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            if (i == 4) begin
                #1 rst = 1'b0;
                #2 rst = 1'b1;
            end
            if (i == 6) cmd.btn_load = 1'b0;
            @(negedge clk);
            n_tests++;
            if (cmd.load !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid_debounce cyc%0d load=%b required 0", i, cmd.load);
            end
        end
        n_tests++;
        if (cmd.down !== 1'b0 || cmd.cnt_in !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_mid_state down=%b cnt_in=%h required 0/0", cmd.down, cmd.cnt_in);
        end
        cmd.sw_val   = 4'h9;
        cmd.btn_load = 1'b1;
        for (int i = 1; i <= 7; i++) @(negedge clk);
        n_tests++;
        if (cmd.load !== 1'b1 || cmd.cnt_in !== 4'h9) begin
            n_fail++;
            $display("FAIL reset_mid_restart load=%b cnt_in=%h required 1/9", cmd.load, cmd.cnt_in);
        end
        #1 rst = 1'b0;
        cmd.btn_load = 1'b0;
        #1;
        n_tests++;
        if (cmd.load !== 1'b0 || cmd.cnt_in !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_mid_pulse_drop load=%b cnt_in=%h required 0/0", cmd.load, cmd.cnt_in);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            n_tests++;
            if (cmd.load !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid_after cyc%0d load=%b required 0", i, cmd.load);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if (($urandom % 7) == 0) cmd.btn_load = ~cmd.btn_load;
            if (($urandom % 7) == 0) cmd.btn_dir = ~cmd.btn_dir;
            if (($urandom % 4) == 0) cmd.sw_val = CW'($urandom_range(0, 15));
            rst = (($urandom % 150) == 0) ? 1'b0 : 1'b1;
            @(negedge clk);
            n_tests++;
            if (cmd.load !== m_load || cmd.down !== m_down || cmd.cnt_in !== m_cnt) begin
                n_fail++;
                $display("FAIL random cyc%0d load=%b down=%b cnt_in=%h required %b/%b/%h",
                         i, cmd.load, cmd.down, cmd.cnt_in, m_load, m_down, m_cnt);
            end
        end
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_clean_load();
        test_glitch();
        test_dir_toggle();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
